// File: rtl/alu_seq_ctrl.sv
// Multi-byte operation sequencer for the 8-bit cpuA ALU: feeds one byte per cycle
// LSB first, chains carry through the ALU flag register and assembles the word result.
module alu_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  zero,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [2:0]            alu_cs,
    output logic                  alu_flagwrite,
    input  logic [7:0]            alu_s
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt, idx_inc;
    logic [1:0]      op_l;
    logic [W-1:0]    opa_l, opb_l, shadow, merged;
    logic            accept, last;
    logic            busy_nxt, done_nxt, fw_nxt;
    logic [7:0]      a_nxt, b_nxt;
    logic [2:0]      cs_nxt;

    // Byte 0 never uses the with-carry ops so a stale ALU flag cannot leak in.
    function automatic logic [2:0] cs_of(input logic [1:0] o, input logic first);
        case (o)
            2'b00:   cs_of = 3'b000;
            2'b01:   cs_of = 3'b001;
            2'b10:   cs_of = first ? 3'b010 : 3'b110;
            default: cs_of = first ? 3'b011 : 3'b101;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next state plus the next values of the registered ALU-side outputs.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        idx_inc   = idx + IW'(1);
        accept    = 1'b0;
        last      = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        a_nxt     = 8'h00;
        b_nxt     = 8'h00;
        cs_nxt    = 3'b000;
        fw_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    a_nxt     = opa[7:0];
                    b_nxt     = opb[7:0];
                    cs_nxt    = cs_of(op, 1'b1);
                    fw_nxt    = op[1];
                end
            end
            RUN: begin
                busy_nxt = 1'b1;
                if (idx == IW'(NBYTES - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt = idx_inc;
                    a_nxt   = 8'(opa_l >> {idx_inc, 3'b000});
                    b_nxt   = 8'(opb_l >> {idx_inc, 3'b000});
                    cs_nxt  = cs_of(op_l, 1'b0);
                    fw_nxt  = op_l[1];
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow with the byte currently on the ALU merged in.
    always_comb begin
        merged = shadow;
        merged[{idx, 3'b000} +: 8] = alu_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_l          <= 2'b00;
            opa_l         <= '0;
            opb_l         <= '0;
            shadow        <= '0;
            result        <= '0;
            zero          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            alu_a         <= 8'h00;
            alu_b         <= 8'h00;
            alu_cs        <= 3'b000;
            alu_flagwrite <= 1'b0;
        end else begin
            busy          <= busy_nxt;
            done          <= done_nxt;
            alu_a         <= a_nxt;
            alu_b         <= b_nxt;
            alu_cs        <= cs_nxt;
            alu_flagwrite <= fw_nxt;
            if (accept) begin
                op_l  <= op;
                opa_l <= opa;
                opb_l <= opb;
            end
            if (state == RUN) begin
                shadow[{idx, 3'b000} +: 8] <= alu_s;
            end
            if (last) begin
                result <= merged;
                zero   <= (merged == '0);
            end
        end
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-byte operation sequencer for the 8-bit cpuA ALU (operand inputs scrA/scrB, operation select alucs, flag-write enable flagwrite, carry/zero flags registered on clk).
- Accepts one NBYTES-wide operation, then drives the ALU one byte per cycle, LSB first.
- Uses ADD/SUB on byte 0 and ADDC/SUBC on higher bytes, so the carry chains through the ALU's registered carry flag.
- Assembles the result bytes, computes a whole-word zero flag and signals completion with a one-cycle done pulse.

Parameters:
NBYTES, 4, operand/result width in bytes (2..8); word width W = 8*NBYTES

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  asynchronous reset, active-low
start  in  1  request; sampled only in IDLE
op  in  2  00 AND, 01 OR, 10 ADD, 11 SUB
opa  in  W  operand A, latched on accept
opb  in  W  operand B, latched on accept
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse, result/zero valid from this cycle
result  out  W  assembled result, held until next completion
zero  out  1  1 when the whole result == 0, held with result
alu_a  out  8  to ALU scrA
alu_b  out  8  to ALU scrB
alu_cs  out  3  to ALU alucs
alu_flagwrite  out  1  to ALU flagwrite
alu_s  in  8  ALU combinational result s

Behaviour:
Reset (rst_n low, asynchronous, any state, including mid-operation):
- State = IDLE, byte index = 0.
- Latched operands and shadow accumulator cleared.
- busy = 0, done = 0, result = 0, zero = 0.
- alu_a = 0, alu_b = 0, alu_cs = 000, alu_flagwrite = 0.
- Any partial operation is discarded.

States are IDLE, RUN and DONE.

IDLE:
- ALU outputs at their reset values.
- On start = 1 at a rising edge: latch op/opa/opb, idx = 0, go to RUN.

RUN (exactly NBYTES cycles):
- alu_a = opa_l[8*idx +: 8], alu_b = opb_l[8*idx +: 8].
- alu_cs:
  - AND = 000 and OR = 001 on every byte.
  - ADD: 010 on idx 0, 110 (ADDC) otherwise.
  - SUB: 011 on idx 0, 101 (SUBC) otherwise.
- alu_flagwrite = 1 for ADD/SUB, 0 for AND/OR.
- Each rising edge: shadow[8*idx +: 8] <= alu_s; idx++.
- At the edge where idx = NBYTES-1, go to DONE.
- ALU outputs are registered, i.e. driven from state/idx registers only, never combinationally from start/opa/opb.

DONE (one cycle):
- On entry edge: result <= shadow with the final byte merged; zero <= (that full value == 0); done <= 1.
- ALU outputs return to IDLE values.
- Next edge: done <= 0, go to IDLE.

Latency:
- Start accepted at edge k; byte i is presented to the ALU during cycle k+1+i.
- done is high in cycle k+1+NBYTES.
- The next start can be accepted at the edge ending the done cycle + 1 (back-to-back period NBYTES+2 cycles).

Ignored start:
- start while busy is ignored: no queueing, latched operands unchanged.

Holding result:
- result/zero change only at DONE entry and keep their previous values during RUN.

Carry/borrow semantics:
- Defined entirely by the ALU flag register; the controller never reads the ALU flags.
- Byte 0 of ADD/SUB must not use the carry/with-borrow op, so a stale flag never affects a new operation.

Zero flag:
- Computed from all assembled bytes by the controller, not from the ALU zeroout (which reflects a single byte only).

Test Plan:
1. Reset mid-RUN: assert rst_n=0 after byte 1 of an ADD -> busy=0, done=0, result=0, alu_cs=000 immediately (asynchronous); after release, a new start completes normally.
2. ADD 0x000000FF + 0x00000001 (NBYTES=4) -> alu_cs sequence 010,110,110,110 with flagwrite=1; done in cycle k+5; result=0x00000100, zero=0.
3. SUB 0x00000100 - 0x00000001 -> alu_cs 011,101,101,101; result=0x000000FF. Then SUB 0x12345678 - 0x12345678 -> result=0x00000000, zero=1.
4. AND 0xF0F0F0F0 & 0x0FF00FF0 -> result=0x00F000F0, flagwrite=0 throughout. OR 0x00000006 | 0x00000005 -> result=0x00000007.
5. start held high continuously across two ADDs, with opa changed during RUN -> the first result uses the originally latched operands; the second operation is accepted only after done; exactly one done pulse per operation, period 6 cycles.
6. ADD 0xFFFFFFFF + 0x00000001 -> result=0x00000000, zero=1. Then ADD 0x00000001 + 0x00000001 -> result=0x00000002, proving the leftover carry is not used on byte 0.
